stream_mux_rr: RTL

// - Parametrised N-input, val/rdy stream mux with round-robin arbitration and a
//   one-entry registered output stage; sequential successor to the 5:1 comb mux.
// - Funnels NINPUTS producer streams (e.g. lane results) into one consumer port
//   and tags each output message with its source index.

---
 rtl/stream_mux_rr.sv | 116 +++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N-input val/rdy stream mux, round-robin arbiter, one-entry output register.
// Define STREAM_MUX_RR_PRIO_EN for fixed lowest-index-first priority instead.
module stream_mux_rr #(
   parameter  int NBITS   = 4,
   parameter  int NINPUTS = 5,
   localparam int SBITS   = $clog2(NINPUTS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NINPUTS-1:0]       in_val,
   output logic [NINPUTS-1:0]       in_rdy,
   input  logic [NINPUTS*NBITS-1:0] in_msg,
   output logic                     out_val,
   input  logic                     out_rdy,
   output logic [NBITS-1:0]         out_msg,
   output logic [SBITS-1:0]         out_src
);

   logic             out_val_q, out_val_d;
   logic [NBITS-1:0] out_msg_q, out_msg_d;
   logic [SBITS-1:0] out_src_q, out_src_d;
   logic [SBITS-1:0] ptr;

   logic             gnt_any;
   logic [SBITS-1:0] gnt_idx;
   logic             accept;
   logic             in_xfer;
   logic             out_xfer;

   // Scan in_val starting at ptr; one spare bit keeps the wrap sum exact.
   always_comb begin
      logic [SBITS:0] sum;
      gnt_any = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      for (int k = 0; k < NINPUTS; k++) begin
         sum = {1'b0, ptr} + (SBITS+1)'(k);
         if (sum >= (SBITS+1)'(NINPUTS)) begin
            sum = sum - (SBITS+1)'(NINPUTS);
         end
         if (!gnt_any && in_val[sum[SBITS-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = sum[SBITS-1:0];
         end
      end
   end

   assign accept   = !out_val_q || out_rdy;
   assign in_xfer  = gnt_any && accept && !reset;
   assign out_xfer = out_val_q && out_rdy;

   always_comb begin
      in_rdy = '0;
      if (in_xfer) begin
         in_rdy[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      out_val_d = out_val_q;
      out_msg_d = out_msg_q;
      out_src_d = out_src_q;
      if (in_xfer) begin
         out_val_d = 1'b1;
         out_msg_d = in_msg[gnt_idx*NBITS +: NBITS];
         out_src_d = gnt_idx;
      end else if (out_xfer) begin
         out_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_val_q <= 1'b0;
         out_msg_q <= '0;
         out_src_q <= '0;
      end else begin
         out_val_q <= out_val_d;
         out_msg_q <= out_msg_d;
         out_src_q <= out_src_d;
      end
   end

`ifdef STREAM_MUX_RR_PRIO_EN
   assign ptr = '0;
`else
   logic [SBITS-1:0] ptr_q, ptr_d;

   // Explicit wrap: NINPUTS need not be a power of two.
   always_comb begin
      ptr_d = ptr_q;
      if (in_xfer) begin
         if (gnt_idx == SBITS'(NINPUTS-1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx + SBITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`endif

   assign out_val = out_val_q;
   assign out_msg = out_msg_q;
   assign out_src = out_src_q;

endmodule
